dac_slot_scheduler: RTL and testbench
=====================================

# dac_slot_scheduler

Sample scheduler for the 10-bit PLB DAC peripheral. It buffers I and Q sample streams written by the register or memory interface in two small FIFOs, then paces them onto the shared DAC data bus at a programmable sample rate. Output is single-channel (I only) or interleaved I/Q. It drives the channel-enable outputs and flags underruns, and sits between the PLB slave register logic and the DAC pin drivers.

## Interface
- DAC_WIDTH, 10, sample/code width
- FIFO_DEPTH, 4, per-channel FIFO entries; power of two, ≥2
- IDLE_CODE, 10'h200, midscale code driven when idle or on underrun
- SPLB_Clk  in  1  sole clock, rising edge
- SPLB_Rst_n  in  1  reset, asynchronous, active-low
- Enable  in  1  run request
- Mode  in  1  0 = I only, 1 = interleaved I/Q
- Rate_Div  in  16  slot period = Rate_Div+1 clocks
- I_Data  in  DAC_WIDTH  I sample; I_Valid in 1; I_Ready out 1
- Q_Data  in  DAC_WIDTH  Q sample; Q_Valid in 1; Q_Ready out 1
- Dac_Data  out  DAC_WIDTH  registered code to DAC
- Dac_Sel  out  1  1 = Dac_Data is I, 0 = Q
- Dac_Strobe  out  1  one-clock pulse per slot update
- OpEnI / OpEnQ  out  1 each  channel output enables
- Underrun  out  1  sticky underrun flag; Underrun_Clr in 1 clears it
- Busy  out  1  scheduler not IDLE

## Operation
- FIFOs: write accepted when Valid && Ready. Ready = !full, taken from registered occupancy. Valid while full is ignored and the data is dropped; the source must hold it.
- States: IDLE, SLOT_I, SLOT_Q.
- IDLE → SLOT_I on an edge with Enable=1. Slot counter cleared to 0 on that edge.
- In a SLOT state the counter increments each clock. A tick occurs when count ≥ Rate_Div (≥ tolerates a live Rate_Div decrease). On a tick the counter returns to 0.
- On a tick in SLOT_I:
  - If the I FIFO is non-empty: pop it, Dac_Data ← head, Dac_Sel ← 1.
  - Else: Dac_Data ← IDLE_CODE, Dac_Sel ← 1, Underrun ← 1.
  - Dac_Strobe ← 1 either way.
  - Next state is SLOT_Q if Mode=1, else SLOT_I. Mode is sampled only at the tick.
- SLOT_Q behaves the same using the Q FIFO with Dac_Sel ← 0. Next state is always SLOT_I.
- Enable=0 in any SLOT state: next edge → IDLE, counter 0, Dac_Data ← IDLE_CODE, no strobe, no pop. FIFO contents are retained.
- OpEnI = (state≠IDLE). OpEnQ = (state≠IDLE) && Mode. Both are registered with the state.
- Busy = (state≠IDLE).
- Underrun: set has priority over Underrun_Clr in the same cycle.
- FIFO occupancy arithmetic uses log2(FIFO_DEPTH)+1-bit pointers. Pointers wrap modulo 2·FIFO_DEPTH. Full when the MSBs differ and the remaining bits are equal.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE, counter 0, FIFOs empty
  - Dac_Data=IDLE_CODE, Dac_Sel=0, Dac_Strobe=0
  - OpEnI=OpEnQ=0, Underrun=0, Busy=0
  - I_Ready=Q_Ready=1
- Enable sampled 1 at edge E0 → SLOT_I after E0. First tick at edge E0+Rate_Div+1. Dac_Data is valid after that edge.
- Slot spacing is Rate_Div+1 clocks. Rate_Div=0 gives one strobe every clock.
- Write-to-pop: a word written at edge W is visible in the FIFO after W and may be popped at a tick on edge W+1 or later.
- Simultaneous events:
  - Write and pop on an empty FIFO: the pop sees empty → underrun, and the written word is kept.
  - Write and pop on a full FIFO: the write is rejected, because Ready was 0.
- Reset asserted mid-slot: all outputs return to reset values immediately and FIFO contents are lost.

## Test plan
- Reset, then Mode=0, Rate_Div=3, write I = 0x001, 0x002, 0x003, Enable=1 → strobes every 4 clocks with Dac_Data 0x001, 0x002, 0x003, Dac_Sel=1. The fourth strobe carries 0x200 and sets Underrun=1.
- Mode=1, Rate_Div=0, I FIFO holds 0x010, 0x011 and Q FIFO holds 0x3F0, 0x3F1 → consecutive-clock outputs 0x010/I, 0x3F0/Q, 0x011/I, 0x3F1/Q. OpEnQ=1 throughout.
- Fill I FIFO with 4 words, hold I_Valid with 0x155 → I_Ready=0 and 0x155 is not stored. After one pop, I_Ready=1 and 0x155 is written.
- Drop Enable mid-run with 2 words queued → next edge: Busy=0, OpEnI=0, Dac_Data=0x200. Re-enable → the queued words are output in order.
- Underrun_Clr pulsed in the same cycle as an underrun tick → Underrun stays 1. Pulse Underrun_Clr alone → Underrun=0.
- Assert SPLB_Rst_n=0 between ticks with the FIFOs non-empty → outputs return to reset values asynchronously. After release the FIFOs are empty and I_Ready=1.

Source files
------------

// File: rtl/dac_slot_scheduler.sv
// Paces buffered I/Q samples onto the shared 10-bit DAC bus at a programmable slot rate.
// Two small FIFOs absorb register/memory writes; the slot FSM pops one sample per tick.
module dac_slot_scheduler #(
    parameter int unsigned          DAC_WIDTH  = 10,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [DAC_WIDTH-1:0] IDLE_CODE  = 10'h200
) (
    input  logic                 SPLB_Clk,
    input  logic                 SPLB_Rst_n,
    input  logic                 Enable,
    input  logic                 Mode,
    input  logic [15:0]          Rate_Div,
    input  logic [DAC_WIDTH-1:0] I_Data,
    input  logic                 I_Valid,
    output logic                 I_Ready,
    input  logic [DAC_WIDTH-1:0] Q_Data,
    input  logic                 Q_Valid,
    output logic                 Q_Ready,
    output logic [DAC_WIDTH-1:0] Dac_Data,
    output logic                 Dac_Sel,
    output logic                 Dac_Strobe,
    output logic                 OpEnI,
    output logic                 OpEnQ,
    output logic                 Underrun,
    input  logic                 Underrun_Clr,
    output logic                 Busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned ChI = 0;
    localparam int unsigned ChQ = 1;

    typedef enum logic [1:0] {StIdle, StSlotI, StSlotQ} state_e;

    state_e                      stateQ, stateD;
    logic [15:0]                 cntQ, cntD;
    logic [DAC_WIDTH-1:0]        dacDataQ, dacDataD;
    logic                        dacSelQ, dacSelD;
    logic                        strobeQ, strobeD;
    logic                        opEnIQ, opEnQQ;
    logic                        underrunQ, underrunSet;

    logic [1:0]                  valid, full, empty, push, pop;
    logic [1:0][DAC_WIDTH-1:0]   wData, head;
    logic                        curCh;

    assign valid = {Q_Valid, I_Valid};
    assign wData = {Q_Data, I_Data};

    // One FIFO per channel; extra pointer MSB tells full from empty.
    for (genvar c = 0; c < 2; c++) begin : gChan
        logic [PW-1:0]        wrPtrQ, rdPtrQ;
        logic [DAC_WIDTH-1:0] mem [FIFO_DEPTH];

        assign empty[c] = (wrPtrQ == rdPtrQ);
        assign full[c]  = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
        assign push[c]  = valid[c] && !full[c];
        assign head[c]  = mem[rdPtrQ[AW-1:0]];

        always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
            if (!SPLB_Rst_n) begin
                wrPtrQ <= '0;
                rdPtrQ <= '0;
            end else begin
                if (push[c]) wrPtrQ <= wrPtrQ + PW'(1);
                if (pop[c])  rdPtrQ <= rdPtrQ + PW'(1);
            end
        end

        always_ff @(posedge SPLB_Clk) begin
            if (push[c]) mem[wrPtrQ[AW-1:0]] <= wData[c];
        end
    end

    assign I_Ready = !full[ChI];
    assign Q_Ready = !full[ChQ];

    always_comb begin
        stateD      = stateQ;
        cntD        = cntQ;
        dacDataD    = dacDataQ;
        dacSelD     = dacSelQ;
        strobeD     = 1'b0;
        pop         = '0;
        underrunSet = 1'b0;
        curCh       = (stateQ == StSlotQ);
        unique case (stateQ)
            StIdle: begin
                if (Enable) begin
                    stateD = StSlotI;
                    cntD   = '0;
                end
            end
            StSlotI, StSlotQ: begin
                if (!Enable) begin
                    stateD   = StIdle;
                    cntD     = '0;
                    dacDataD = IDLE_CODE;
                end else if (cntQ >= Rate_Div) begin
                    // >= so a live decrease of Rate_Div cannot strand the counter
                    cntD    = '0;
                    strobeD = 1'b1;
                    dacSelD = !curCh;
                    if (!empty[curCh]) begin
                        pop[curCh] = 1'b1;
                        dacDataD   = head[curCh];
                    end else begin
                        dacDataD    = IDLE_CODE;
                        underrunSet = 1'b1;
                    end
                    stateD = (stateQ == StSlotI && Mode) ? StSlotQ : StSlotI;
                end else begin
                    cntD = cntQ + 16'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            dacDataQ <= IDLE_CODE;
            dacSelQ  <= 1'b0;
            strobeQ  <= 1'b0;
            opEnIQ   <= 1'b0;
            opEnQQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            dacDataQ <= dacDataD;
            dacSelQ  <= dacSelD;
            strobeQ  <= strobeD;
            opEnIQ   <= (stateD != StIdle);
            opEnQQ   <= (stateD != StIdle) && Mode;
        end
    end

    // A new underrun wins over a clear in the same cycle.
    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            underrunQ <= 1'b0;
        end else if (underrunSet) begin
            underrunQ <= 1'b1;
        end else if (Underrun_Clr) begin
            underrunQ <= 1'b0;
        end
    end

    assign Dac_Data   = dacDataQ;
    assign Dac_Sel    = dacSelQ;
    assign Dac_Strobe = strobeQ;
    assign OpEnI      = opEnIQ;
    assign OpEnQ      = opEnQQ;
    assign Underrun   = underrunQ;
    assign Busy       = (stateQ != StIdle);

endmodule

// File: tb/tb_dac_slot_scheduler.sv
// Self-checking bench for dac_slot_scheduler: table of streaming scenarios plus corner sequences,
// with a strobe scoreboard checking data, lane select, channel enables and slot timing.
`timescale 1ns/1ps
module tb_dac_slot_scheduler;

    localparam logic [9:0] IDLE = 10'h200;

    logic        SPLB_Clk = 1'b0;
    logic        SPLB_Rst_n = 1'b0;
    logic        Enable = 1'b0;
    logic        Mode = 1'b0;
    logic [15:0] Rate_Div = '0;
    logic [9:0]  I_Data = '0;
    logic        I_Valid = 1'b0;
    logic        I_Ready;
    logic [9:0]  Q_Data = '0;
    logic        Q_Valid = 1'b0;
    logic        Q_Ready;
    logic [9:0]  Dac_Data;
    logic        Dac_Sel;
    logic        Dac_Strobe;
    logic        OpEnI;
    logic        OpEnQ;
    logic        Underrun;
    logic        Underrun_Clr = 1'b0;
    logic        Busy;

    always #5 SPLB_Clk = ~SPLB_Clk;

    dac_slot_scheduler dut (
        .SPLB_Clk    (SPLB_Clk),
        .SPLB_Rst_n  (SPLB_Rst_n),
        .Enable      (Enable),
        .Mode        (Mode),
        .Rate_Div    (Rate_Div),
        .I_Data      (I_Data),
        .I_Valid     (I_Valid),
        .I_Ready     (I_Ready),
        .Q_Data      (Q_Data),
        .Q_Valid     (Q_Valid),
        .Q_Ready     (Q_Ready),
        .Dac_Data    (Dac_Data),
        .Dac_Sel     (Dac_Sel),
        .Dac_Strobe  (Dac_Strobe),
        .OpEnI       (OpEnI),
        .OpEnQ       (OpEnQ),
        .Underrun    (Underrun),
        .Underrun_Clr(Underrun_Clr),
        .Busy        (Busy)
    );

    typedef struct packed {
        logic [9:0] data;
        logic       sel;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [15:0] rd;
        int          n;
        logic [9:0]  iBase;
        logic [9:0]  qBase;
        logic        extra;
    } vec_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails = 0;
    int   cyc = 0;
    int   nextStrobeCyc = 0;
    int   rdCur = 0;

    always @(posedge SPLB_Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation and land on schedule.
    always @(negedge SPLB_Clk) begin : mon
        exp_t e;
        if (Dac_Strobe) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_strobe: got data 0x%0h sel %0b, expected no strobe",
                         Dac_Data, Dac_Sel);
            end else begin
                e = expQ.pop_front();
                check("dac_data", 32'(Dac_Data), 32'(e.data));
                check("dac_sel", 32'(Dac_Sel), 32'(e.sel));
                check("strobe_cycle", cyc, nextStrobeCyc);
                check("open_i", 32'(OpEnI), 1);
                check("open_q", 32'(OpEnQ), 32'(Mode));
                nextStrobeCyc = nextStrobeCyc + rdCur + 1;
            end
        end
    end

    task automatic pushExp(input logic [9:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sel  = s;
        expQ.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_dac_data"}, 32'(Dac_Data), 32'(IDLE));
        check({tag, "_dac_sel"}, 32'(Dac_Sel), 0);
        check({tag, "_strobe"}, 32'(Dac_Strobe), 0);
        check({tag, "_open_i"}, 32'(OpEnI), 0);
        check({tag, "_open_q"}, 32'(OpEnQ), 0);
        check({tag, "_underrun"}, 32'(Underrun), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_i_ready"}, 32'(I_Ready), 1);
        check({tag, "_q_ready"}, 32'(Q_Ready), 1);
    endtask

    task automatic resetDut();
        Enable       = 1'b0;
        I_Valid      = 1'b0;
        Q_Valid      = 1'b0;
        Underrun_Clr = 1'b0;
        SPLB_Rst_n   = 1'b0;
        expQ.delete();
        repeat (2) @(negedge SPLB_Clk);
        #1;
        SPLB_Rst_n = 1'b1;
        @(negedge SPLB_Clk);
        #1;
    endtask

    // Called at negedge+1; the word is taken on the next rising edge with Ready high.
    task automatic writeWord(input bit ch, input logic [9:0] d);
        int k = 0;
        if (ch == 1'b0) begin
            I_Data  = d;
            I_Valid = 1'b1;
            while (!I_Ready && k < 200) begin @(negedge SPLB_Clk); #1; k++; end
        end else begin
            Q_Data  = d;
            Q_Valid = 1'b1;
            while (!Q_Ready && k < 200) begin @(negedge SPLB_Clk); #1; k++; end
        end
        if (k >= 200) begin
            nChecks++;
            nFails++;
            $display("FAIL write_timeout: got ready=0 for 200 cycles, expected ready=1");
        end
        @(negedge SPLB_Clk);
        #1;
        I_Valid = 1'b0;
        Q_Valid = 1'b0;
    endtask

    // Enable sampled at the next edge E0; first strobe follows edge E0+rd+1.
    task automatic startRun(input logic [15:0] rd);
        rdCur         = int'(rd);
        Rate_Div      = rd;
        nextStrobeCyc = cyc + int'(rd) + 2;
        Enable        = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        int k = 0;
        while (expQ.size() != 0 && k < 5000) begin @(negedge SPLB_Clk); #1; k++; end
        check(name, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic runVec(input vec_t v);
        resetDut();
        Mode = v.mode;
        for (int k = 0; k < v.n; k++) begin
            writeWord(1'b0, v.iBase + 10'(k));
            if (v.mode) writeWord(1'b1, v.qBase + 10'(k));
        end
        for (int k = 0; k < v.n; k++) begin
            pushExp(v.iBase + 10'(k), 1'b1);
            if (v.mode) pushExp(v.qBase + 10'(k), 1'b0);
        end
        if (v.extra) pushExp(IDLE, 1'b1);
        check("vec_underrun_pre", 32'(Underrun), 0);
        startRun(v.rd);
        waitDrain("vec_drain");
        check("vec_underrun_post", 32'(Underrun), 32'(v.extra));
        Enable = 1'b0;
        @(negedge SPLB_Clk);
        #1;
        check("vec_busy_off", 32'(Busy), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 1'b0, rd: 16'd3, n: 3, iBase: 10'h001, qBase: 10'h000, extra: 1'b1};
        vecs[1] = '{mode: 1'b1, rd: 16'd0, n: 2, iBase: 10'h010, qBase: 10'h3F0, extra: 1'b0};
        vecs[2] = '{mode: 1'b0, rd: 16'd0, n: 4, iBase: 10'h0C0, qBase: 10'h000, extra: 1'b0};
        vecs[3] = '{mode: 1'b1, rd: 16'd2, n: 3, iBase: 10'h123, qBase: 10'h2F0, extra: 1'b1};
        vecs[4] = '{mode: 1'b1, rd: 16'd5, n: 1, iBase: 10'h3FF, qBase: 10'h001, extra: 1'b0};

        SPLB_Rst_n = 1'b0;
        repeat (2) @(negedge SPLB_Clk);
        #1;
        checkReset("por");
        SPLB_Rst_n = 1'b1;
        @(negedge SPLB_Clk);
        #1;

        for (int i = 0; i < 5; i++) runVec(vecs[i]);

        // Full FIFO back-pressure: held word enters only after a pop frees a slot.
        resetDut();
        Mode = 1'b0;
        for (int k = 0; k < 4; k++) writeWord(1'b0, 10'h100 + 10'(k));
        check("full_ready", 32'(I_Ready), 0);
        I_Data  = 10'h155;
        I_Valid = 1'b1;
        repeat (3) @(negedge SPLB_Clk);
        #1;
        check("full_ready_held", 32'(I_Ready), 0);
        for (int k = 0; k < 4; k++) pushExp(10'h100 + 10'(k), 1'b1);
        pushExp(10'h155, 1'b1);
        startRun(16'd1);
        begin
            int k = 0;
            while (!I_Ready && k < 100) begin @(negedge SPLB_Clk); #1; k++; end
        end
        check("ready_after_pop", 32'(I_Ready), 1);
        @(negedge SPLB_Clk);
        #1;
        I_Valid = 1'b0;
        waitDrain("full_drain");
        Enable = 1'b0;
        check("full_no_underrun", 32'(Underrun), 0);

        // Disable mid-run keeps queued words for the next run.
        resetDut();
        Mode = 1'b0;
        for (int k = 0; k < 4; k++) writeWord(1'b0, 10'h0A0 + 10'(k));
        pushExp(10'h0A0, 1'b1);
        pushExp(10'h0A1, 1'b1);
        startRun(16'd2);
        waitDrain("pause_drain1");
        Enable = 1'b0;
        @(negedge SPLB_Clk);
        #1;
        check("pause_busy", 32'(Busy), 0);
        check("pause_open_i", 32'(OpEnI), 0);
        check("pause_dac_data", 32'(Dac_Data), 32'(IDLE));
        check("pause_strobe", 32'(Dac_Strobe), 0);
        repeat (5) @(negedge SPLB_Clk);
        #1;
        pushExp(10'h0A2, 1'b1);
        pushExp(10'h0A3, 1'b1);
        startRun(16'd2);
        waitDrain("pause_drain2");
        Enable = 1'b0;
        check("pause_no_underrun", 32'(Underrun), 0);

        // Underrun set beats a simultaneous clear; a lone clear then works.
        resetDut();
        Mode = 1'b0;
        pushExp(IDLE, 1'b1);
        startRun(16'd3);
        repeat (4) @(negedge SPLB_Clk);
        #1;
        Underrun_Clr = 1'b1;
        @(negedge SPLB_Clk);
        #1;
        Underrun_Clr = 1'b0;
        Enable       = 1'b0;
        check("clr_vs_set", 32'(Underrun), 1);
        waitDrain("clr_drain");
        @(negedge SPLB_Clk);
        #1;
        check("clr_hold", 32'(Underrun), 1);
        Underrun_Clr = 1'b1;
        @(negedge SPLB_Clk);
        #1;
        Underrun_Clr = 1'b0;
        check("clr_alone", 32'(Underrun), 0);

        // Asynchronous reset between ticks flushes the FIFOs.
        resetDut();
        Mode = 1'b0;
        writeWord(1'b0, 10'h2A1);
        writeWord(1'b0, 10'h2A2);
        pushExp(10'h2A1, 1'b1);
        startRun(16'd5);
        waitDrain("rst_drain");
        repeat (2) @(negedge SPLB_Clk);
        #1;
        check("pre_rst_busy", 32'(Busy), 1);
        SPLB_Rst_n = 1'b0;
        #1;
        checkReset("midrst");
        Enable = 1'b0;
        @(negedge SPLB_Clk);
        #1;
        SPLB_Rst_n = 1'b1;
        @(negedge SPLB_Clk);
        #1;
        check("post_rst_i_ready", 32'(I_Ready), 1);
        pushExp(IDLE, 1'b1);
        startRun(16'd0);
        waitDrain("post_rst_drain");
        Enable = 1'b0;
        check("post_rst_underrun", 32'(Underrun), 1);
        @(negedge SPLB_Clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
